// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Single-outstanding RV32I load/store sequencer sitting between the CPU
//   pipeline and a simple memory controller. Computes the effective address,
//   checks alignment/legality, issues a one-cycle start pulse, waits for the
//   memory ready (with a bounded wait), and returns an extended load result.
//
// Parameters
//   TIMEOUT        : max WAIT cycles before the access is aborted with err
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   req_*          : CPU request (valid/ready, store flag, funct3, base, imm,
//                    store data); captured only when accepted in IDLE
//   resp_done      : one-cycle completion pulse
//   resp_rdata     : extended load data (0 for stores/errors)
//   resp_err       : misaligned / illegal / timeout flag
//   mem_enable     : one-cycle start pulse to memory controller
//   mem_addr       : 24-bit byte address
//   mem_we         : write enable
//   mem_instr_mode : 00 word, 01 byte, 10 half
//   mem_data_in    : store data, low-aligned, masked to width
//   mem_data_out   : read data from memory
//   mem_op_r       : memory ready / read data valid
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_imm,
    input  logic [31:0] req_wdata,
    output logic        resp_done,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_enable,
    output logic [23:0] mem_addr,
    output logic        mem_we,
    output logic [1:0]  mem_instr_mode,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_op_r
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_done_q, resp_done_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          mem_enable_q, mem_enable_d;
    logic [23:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [1:0]    mem_mode_q, mem_mode_d;
    logic [31:0]   mem_din_q, mem_din_d;

    // -----------------------------------------------------------------------
    // Request decode (only meaningful while in IDLE)
    // -----------------------------------------------------------------------
    logic [31:0] ea;
    logic        is_byte, is_half, is_word;
    logic        illegal, misalign;
    logic [1:0]  req_mode;
    logic [31:0] req_din;
    logic        unused_ea_hi;

    assign ea           = req_base + {{20{req_imm[11]}}, req_imm};
    // Memory space is 24 bits; the top byte of the sum is intentionally dropped.
    assign unused_ea_hi = ^ea[31:24];

    assign is_byte  = (req_funct3[1:0] == 2'b00);
    assign is_half  = (req_funct3[1:0] == 2'b01);
    assign is_word  = (req_funct3 == 3'b010);
    // 011, 11x are undefined; 10x (unsigned) exist only for loads.
    assign illegal  = (req_funct3 == 3'b011) ||
                      (req_funct3[2] && (req_funct3[1] || req_store));
    assign misalign = (is_half && ea[0]) || (is_word && (ea[1:0] != 2'b00));

    always_comb begin
        req_mode = 2'b00;
        req_din  = req_wdata;
        if (is_byte) begin
            req_mode = 2'b01;
            req_din  = {24'h0, req_wdata[7:0]};
        end else if (is_half) begin
            req_mode = 2'b10;
            req_din  = {16'h0, req_wdata[15:0]};
        end
    end

    // Load extension keyed on the captured funct3.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
            3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
            3'b100:  load_ext = {24'h0, d[7:0]};
            3'b101:  load_ext = {16'h0, d[15:0]};
            default: load_ext = d;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_mode_d   = mem_mode_q;
        mem_din_d    = mem_din_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    funct3_d     = req_funct3;
                    resp_rdata_d = 32'h0;
                    if (illegal || misalign) begin
                        // Rejected before any memory traffic.
                        state_d    = S_DONE;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                        resp_err_d = 1'b0;
                        mem_addr_d = ea[23:0];
                        mem_we_d   = req_store;
                        mem_mode_d = req_mode;
                        mem_din_d  = req_din;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A ready on the final allowed cycle still wins over timeout.
                if (mem_op_r) begin
                    state_d      = S_DONE;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? 32'h0 : load_ext(funct3_q, mem_data_out);
                    mem_we_d     = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d      = S_DONE;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'h0;
                    mem_we_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are registered off the next state.
    assign req_ready_d  = (state_d == S_IDLE);
    assign resp_done_d  = (state_d == S_DONE);
    assign mem_enable_d = (state_d == S_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            funct3_q     <= 3'b000;
            req_ready_q  <= 1'b1;
            resp_done_q  <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_addr_q   <= 24'h0;
            mem_we_q     <= 1'b0;
            mem_mode_q   <= 2'b00;
            mem_din_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            req_ready_q  <= req_ready_d;
            resp_done_q  <= resp_done_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_enable_q <= mem_enable_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_mode_q   <= mem_mode_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_done      = resp_done_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_enable     = mem_enable_q;
    assign mem_addr       = mem_addr_q;
    assign mem_we         = mem_we_q;
    assign mem_instr_mode = mem_mode_q;
    assign mem_data_in    = mem_din_q;

endmodule
